// File: rtl/lr_pass_sequencer_if.sv
// Handshake and sample bus between the sample source, the pass
// sequencer and the mean/coefficient/error units.
interface lr_pass_sequencer_if #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 8
);
  logic              start;
  logic [DATA_W-1:0] inX;
  logic [DATA_W-1:0] inY;
  logic              inValid;
  logic              inLast;
  logic              loadReady;
  logic [DATA_W-1:0] x;
  logic [DATA_W-1:0] y;
  logic              sampleValid;
  logic              meanStart;
  logic              calcStart;
  logic              errStart;
  logic              meanReady;
  logic              calcReady;
  logic              errReady;
  logic              busy;
  logic              errDone;
  logic [ADDR_W-1:0] count;
  logic              wdFault;

  modport master (
    output start, inX, inY, inValid, inLast,
    output meanReady, calcReady, errReady,
    input  loadReady, x, y, sampleValid,
    input  meanStart, calcStart, errStart,
    input  busy, errDone, count, wdFault
  );

  modport slave (
    input  start, inX, inY, inValid, inLast,
    input  meanReady, calcReady, errReady,
    output loadReady, x, y, sampleValid,
    output meanStart, calcStart, errStart,
    output busy, errDone, count, wdFault
  );
endinterface

// File: rtl/lr_pass_sequencer.sv
// Sample buffer and three-pass replay FSM for linear regression.
// Optional WAIT watchdog enabled by defining LR_WATCHDOG_EN.
module lr_pass_sequencer #(
  parameter int DATA_W   = 20,
  parameter int DEPTH    = 150,
  parameter int ADDR_W   = 8,
  parameter int WD_LIMIT = 1024
) (
  input logic clk,
  input logic rst,
  lr_pass_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, LOAD,
    M_START, M_RUN, M_WAIT,
    C_START, C_RUN, C_WAIT,
    E_START, E_RUN, E_WAIT,
    DONE
  } state_t;

  state_t state;
  state_t nxt;

  logic [2*DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]   ptr;
  logic                rdyFlag;
  logic                curReady;
  logic                isStart;
  logic                isRun;
  logic                isWait;
  logic                lastSlot;

  if (DEPTH > (1 << ADDR_W) || WD_LIMIT < 1) begin : gBadCfg
    $error("lr_pass_sequencer: bad parameters");
  end

  assign isStart  = state inside {M_START, C_START, E_START};
  assign isRun    = state inside {M_RUN, C_RUN, E_RUN};
  assign isWait   = state inside {M_WAIT, C_WAIT, E_WAIT};
  assign lastSlot = bus.count == ADDR_W'(DEPTH - 1);

  always_comb begin
    nxt = IDLE;
    case (state)
      M_START: nxt = M_RUN;
      M_RUN:   nxt = M_WAIT;
      M_WAIT:  nxt = C_START;
      C_START: nxt = C_RUN;
      C_RUN:   nxt = C_WAIT;
      C_WAIT:  nxt = E_START;
      E_START: nxt = E_RUN;
      E_RUN:   nxt = E_WAIT;
      E_WAIT:  nxt = DONE;
      default: nxt = IDLE;
    endcase
  end

  // only the ready belonging to the active pass is visible
  always_comb begin
    curReady = 1'b0;
    unique case (1'b1)
      state inside {M_START, M_RUN, M_WAIT}:
        curReady = bus.meanReady;
      state inside {C_START, C_RUN, C_WAIT}:
        curReady = bus.calcReady;
      state inside {E_START, E_RUN, E_WAIT}:
        curReady = bus.errReady;
      default: curReady = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == LOAD && bus.inValid)
      mem[bus.count] <= {bus.inX, bus.inY};
  end

`ifdef LR_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_LIMIT + 1);
  logic [WD_W-1:0] wdCnt;
`else
  assign bus.wdFault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      ptr             <= '0;
      rdyFlag         <= 1'b0;
      bus.loadReady   <= 1'b0;
      bus.sampleValid <= 1'b0;
      bus.meanStart   <= 1'b0;
      bus.calcStart   <= 1'b0;
      bus.errStart    <= 1'b0;
      bus.busy        <= 1'b0;
      bus.errDone     <= 1'b0;
      bus.count       <= '0;
      bus.x           <= '0;
      bus.y           <= '0;
`ifdef LR_WATCHDOG_EN
      bus.wdFault     <= 1'b0;
      wdCnt           <= '0;
`endif
    end else begin
      bus.meanStart <= 1'b0;
      bus.calcStart <= 1'b0;
      bus.errStart  <= 1'b0;
      bus.errDone   <= 1'b0;
      if ((isStart || isRun) && curReady)
        rdyFlag <= 1'b1;
      unique case (1'b1)
        state == IDLE: begin
          if (bus.start) begin
            state         <= LOAD;
            bus.count     <= '0;
            bus.loadReady <= 1'b1;
            bus.busy      <= 1'b1;
`ifdef LR_WATCHDOG_EN
            bus.wdFault   <= 1'b0;
`endif
          end
        end
        state == LOAD: begin
          if (bus.inValid) begin
            bus.count <= bus.count + 1'b1;
            if (bus.inLast || lastSlot) begin
              state         <= M_START;
              bus.loadReady <= 1'b0;
              bus.meanStart <= 1'b1;
              rdyFlag       <= 1'b0;
            end
          end
        end
        isStart: begin
          // slot 0 is fetched here so RUN presents one sample per cycle
          ptr             <= ADDR_W'(1);
          bus.x           <= mem[0][2*DATA_W-1:DATA_W];
          bus.y           <= mem[0][DATA_W-1:0];
          bus.sampleValid <= 1'b1;
          state           <= nxt;
        end
        isRun: begin
          if (ptr == bus.count) begin
            bus.sampleValid <= 1'b0;
            state           <= nxt;
`ifdef LR_WATCHDOG_EN
            wdCnt           <= '0;
`endif
          end else begin
            bus.x <= mem[ptr][2*DATA_W-1:DATA_W];
            bus.y <= mem[ptr][DATA_W-1:0];
            ptr   <= ptr + 1'b1;
          end
        end
        isWait: begin
          if (rdyFlag || curReady) begin
            state   <= nxt;
            rdyFlag <= 1'b0;
            unique case (1'b1)
              nxt == C_START: bus.calcStart <= 1'b1;
              nxt == E_START: bus.errStart  <= 1'b1;
              default:        bus.errDone   <= 1'b1;
            endcase
          end
`ifdef LR_WATCHDOG_EN
          else if (wdCnt == WD_W'(WD_LIMIT - 1)) begin
            state       <= IDLE;
            bus.busy    <= 1'b0;
            bus.wdFault <= 1'b1;
          end else begin
            wdCnt <= wdCnt + 1'b1;
          end
`endif
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
